center_light: RTL and testbench
===============================

Name: center_light

Overview:
- Center-position light cell of a tug-of-war LED playfield; one instance sits between a left-neighbor light and a right-neighbor light.
- Each clock it moves the "rope" marker off or onto the center position. Inputs are the two player presses (L, R) and the neighbors' light states (NL, NR).
- The center light is lit out of reset, which is the start-of-game position.

Parameters:
- RESET_ON, 1, value of lightOn while reset is asserted / after reset release (1 = center lit, 0 = dark).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- L  input  1  left-player press for this cycle (already debounced/single-pulsed upstream).
- R  input  1  right-player press for this cycle.
- NL  input  1  current state of left-neighbor light (1 = lit).
- NR  input  1  current state of right-neighbor light (1 = lit).
- lightOn  output  1  registered state of this light (1 = lit).

Behaviour:
- One clock; reset is asynchronous and active-high.
- Two-state FSM, state stored in a single flop that drives lightOn directly (registered output, no combinational path from inputs).
- Reset: while reset=1, lightOn = RESET_ON (1) immediately, independent of clk. First update after release occurs on the first rising edge with reset=0.
- State ON (lightOn=1):
  - L=1 & R=0 -> OFF (marker moves left).
  - L=0 & R=1 -> OFF (marker moves right).
  - L=R (both 0 or both 1) -> stay ON.
  - NL/NR are ignored in ON.
- State OFF (lightOn=0):
  - NR=1 & L=1 & R=0 -> ON (marker arrives from the right).
  - NL=1 & R=1 & L=0 -> ON (marker arrives from the left).
  - Otherwise stay OFF. This includes:
    - L=R;
    - L=1 with NR=0;
    - R=1 with NL=0;
    - NL=1 with only L pressed.
- Latency: exactly one clock from input sampling to lightOn change.
- Simultaneous presses (L=R=1) never change state.
- NL=NR=1 (illegal in a valid game) obeys the same equations; no special handling.
- Reset asserted mid-game forces lightOn=RESET_ON asynchronously and overrides all inputs.
- Inputs sampled only at the rising edge. No X propagation from unused inputs: ON ignores NL/NR.

Test Plan:
- Reset=1 with all inputs 0 -> lightOn=1 before any clock edge. Hold reset 1 cycle -> lightOn stays 1.
- Release reset; L=1, R=0, NR=1 for one edge -> lightOn=0. Keep L=1, NR=1 one more edge -> lightOn=1 (re-entry from right). Then NR=0, L=1 one edge -> lightOn=0.
- From OFF: L=0, R=1, NL=1 one edge -> lightOn=1. Then NL=0, R=1 one edge -> lightOn=0.
- From OFF: L=1, R=0, NL=0, NR=0 for two edges -> lightOn stays 0. L=1, R=1, NR=1 -> lightOn stays 0. L=0, R=0 -> stays 0.
- From ON (after reset): L=1, R=1 for several edges -> lightOn stays 1. L=0, R=0 with NL=1, NR=1 -> stays 1.
- Mid-stream reset: with lightOn=0, assert reset between clock edges -> lightOn=1 immediately (asynchronous). Release -> normal operation resumes on the next edge.

Source files
------------

// File: rtl/center_light.sv
// Center cell of a tug-of-war LED playfield: tracks whether the rope marker
// sits on the center position, moving it off or back on from a neighbor.
module center_light #(
    parameter bit RESET_ON = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic L,
    input  logic R,
    input  logic NL,
    input  logic NR,
    output logic lightOn
);

    typedef enum logic {
        S_OFF = 1'b0,
        S_ON  = 1'b1
    } state_t;

    state_t r_state;
    logic   w_arrive;

    // The marker arrives only when exactly one press pulls it in from the
    // lit neighbor on the opposite side of the press direction.
    assign w_arrive = (L & ~R & NR) | (R & ~L & NL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= state_t'(RESET_ON);
        end else begin
            case (r_state)
                S_ON:    r_state <= (L ^ R) ? S_OFF : S_ON;
                S_OFF:   r_state <= w_arrive ? S_ON : S_OFF;
                default: r_state <= state_t'(RESET_ON);
            endcase
        end
    end

    assign lightOn = r_state;

endmodule

// File: tb/tb_center_light.sv
// Self-checking bench for center_light: directed vector table, async reset
// sequences, and randomized stimulus against a rule-level reference model.
module tb_center_light;

    logic clk = 1'b0;
    logic reset, L, R, NL, NR;
    logic lightOn;

    int n_checks = 0;
    int n_errors = 0;

    center_light #(.RESET_ON(1'b1)) dut (
        .clk    (clk),
        .reset  (reset),
        .L      (L),
        .R      (R),
        .NL     (NL),
        .NR     (NR),
        .lightOn(lightOn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic l;
        logic r;
        logic nl;
        logic nr;
        logic exp;
    } vec_t;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: lightOn=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic l, input logic r, input logic nl, input logic nr);
        L = l; R = r; NL = nl; NR = nr;
        @(posedge clk);
        #1;
    endtask

    // Reference: a lone press pushes the marker away from center; it comes
    // back only when a lone press pulls it from the lit neighbor it is in.
    function automatic logic model_next(input logic on, input logic l, input logic r,
                                        input logic nl, input logic nr);
        int presses;
        presses = int'(l) + int'(r);
        if (on) return (presses == 1) ? 1'b0 : 1'b1;
        if (presses != 1) return 1'b0;
        if (l) return nr;
        return nl;
    endfunction

    vec_t tbl[16];
    logic model;

    initial begin
        tbl[0]  = '{1, 0, 0, 1, 0};
        tbl[1]  = '{1, 0, 0, 1, 1};
        tbl[2]  = '{1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 1};
        tbl[4]  = '{0, 1, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 0, 0};
        tbl[10] = '{1, 1, 1, 1, 0};
        tbl[11] = '{0, 1, 1, 0, 1};
        tbl[12] = '{1, 1, 0, 0, 1};
        tbl[13] = '{1, 1, 0, 0, 1};
        tbl[14] = '{0, 0, 1, 1, 1};
        tbl[15] = '{0, 1, 0, 0, 0};

        reset = 1'b1; L = 1'b0; R = 1'b0; NL = 1'b0; NR = 1'b0;
        #1;
        check("reset_before_edge", lightOn, 1'b1);
        @(posedge clk); #1;
        check("reset_held", lightOn, 1'b1);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].l, tbl[i].r, tbl[i].nl, tbl[i].nr);
            check($sformatf("vec%0d", i), lightOn, tbl[i].exp);
        end

        // Mid-stream async reset while dark, overriding a lone press.
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", lightOn, 1'b1);
        L = 1'b1; R = 1'b0; NL = 1'b0; NR = 1'b0;
        @(posedge clk); #1;
        check("reset_overrides_press", lightOn, 1'b1);
        reset = 1'b0;
        step(1, 0, 0, 0);
        check("resume_after_reset", lightOn, 1'b0);
        step(1, 0, 0, 1);
        check("resume_reentry", lightOn, 1'b1);

        model = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic l, r, nl, nr, exp;
            if ($urandom_range(0, 39) == 0) begin
                #1;
                reset = 1'b1;
                #1;
                model = 1'b1;
                check("rand_async_reset", lightOn, model);
                reset = 1'b0;
            end
            l  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            nl = 1'($urandom_range(0, 1));
            nr = 1'($urandom_range(0, 1));
            exp = model_next(model, l, r, nl, nr);
            step(l, r, nl, nr);
            check($sformatf("rand%0d", i), lightOn, exp);
            model = exp;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
